// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and default operand widths for the times table RAM
package tt_pkg;

  localparam int TT_WA = 3;
  localparam int TT_WB = 3;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } tt_state_e;

endpackage

// File: rtl/tt_ram.sv
// rtl/tt_ram.sv - single-port synchronous RAM with registered read, contents untouched by reset
module tt_ram #(
  parameter int W     = 6,
  parameter int AW    = 6,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write when enabled; the read data is registered and returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/times_table_ram.sv
// rtl/times_table_ram.sv - builds an a*b lookup table by accumulation, then serves lookups with latency 2
module times_table_ram
  import tt_pkg::*;
#(
  parameter int WA = TT_WA,
  parameter int WB = TT_WB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  output logic             out_valid,
  output logic [WA+WB-1:0] result,
  output logic             init_done
);

  localparam int WR    = WA + WB;
  localparam int DEPTH = 2 ** (WA + WB);

  tt_state_e     state;
  tt_state_e     state_next;
  logic [WR-1:0] cnt;
  logic [WR-1:0] acc;
  logic [WR-1:0] acc_next;
  logic [WA-1:0] ia;
  logic [WB-1:0] ib;
  logic          ram_we;
  logic [WR-1:0] ram_addr;
  logic [WR-1:0] ram_rdata;
  logic          accept;
  logic          rd_valid;

  // Build address {ia,ib}: ib is the inner (low) index, ia the outer (high) index.
  assign ia = cnt[WR-1:WB];
  assign ib = cnt[WB-1:0];

  // ia*ib as a running sum: restart at zero on each new row, otherwise add ia.
  assign acc_next = (ib == '0) ? '0 : acc + {{WB{1'b0}}, ia};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Leave INIT after writing the last entry; SERVE only exits through reset.
  always_comb begin
    state_next = state;
    if (state == INIT && cnt == WR'(DEPTH - 1)) begin
      state_next = SERVE;
    end
  end

  // State-decoded outputs and the RAM port mux between table build and lookups.
  always_comb begin
    init_done = (state == SERVE);
    in_ready  = init_done;
    accept    = in_valid && init_done;
    ram_we    = (state == INIT);
    ram_addr  = (state == INIT) ? cnt : {a, b};
  end

  // Table build counter and accumulator advance once per INIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      acc <= acc_next;
    end
  end

  // Request pipeline: RAM read stage, then output register holding the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      rd_valid  <= accept;
      out_valid <= rd_valid;
      if (rd_valid) begin
        result <= ram_rdata;
      end
    end
  end

  tt_ram #(
    .W    (WR),
    .AW   (WR),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(acc_next),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_times_table_ram.sv
// tb/tb_times_table_ram.sv - directed self-checking bench for times_table_ram at 3x3 and 4x2
module tb_times_table_ram;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] a;
  logic [2:0] b;
  logic       out_valid;
  logic [5:0] result;
  logic       init_done;

  logic       in_valid2;
  logic       in_ready2;
  logic [3:0] a2;
  logic [1:0] b2;
  logic       out_valid2;
  logic [5:0] result2;
  logic       init_done2;

  int pass_count  = 0;
  int check_count = 0;

  times_table_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .result   (result),
    .init_done(init_done)
  );

  times_table_ram #(.WA(4), .WB(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .a        (a2),
    .b        (b2),
    .out_valid(out_valid2),
    .result   (result2),
    .init_done(init_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    check_count++;
    if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b expected 0", init_done);
    else pass_count++;
    check_count++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else pass_count++;
    check_count++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_count++;
    check_count++;
    if (result !== 6'd0) $display("FAIL reset_result: got %0d expected 0", result);
    else pass_count++;
    check_count++;
    if (init_done2 !== 1'b0 || out_valid2 !== 1'b0) $display("FAIL reset_dut2: got init_done %b out_valid %b expected 0 0", init_done2, out_valid2);
    else pass_count++;
  endtask

  task automatic test_init();
    int early = 0;
    int ov = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i < 64 && (init_done || in_ready || init_done2)) early++;
      if (out_valid || out_valid2) ov++;
    end
    check_count++;
    if (early !== 0) $display("FAIL init_early: got %0d early-ready cycles expected 0", early);
    else pass_count++;
    check_count++;
    if (init_done !== 1'b1 || in_ready !== 1'b1) $display("FAIL init_done_64: got %b/%b expected 1/1", init_done, in_ready);
    else pass_count++;
    check_count++;
    if (init_done2 !== 1'b1 || in_ready2 !== 1'b1) $display("FAIL init_done_64_wide: got %b/%b expected 1/1", init_done2, in_ready2);
    else pass_count++;
    check_count++;
    if (ov !== 0) $display("FAIL init_out_valid: got %0d valid cycles expected 0", ov);
    else pass_count++;
  endtask

  task automatic test_single();
    logic [2:0] ta [3] = '{3'd7, 3'd0, 3'd3};
    logic [2:0] tb [3] = '{3'd7, 3'd5, 3'd6};
    logic [5:0] te [3] = '{6'd49, 6'd0, 6'd18};
    for (int i = 0; i < 3; i++) begin
      a = ta[i]; b = tb[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_count++;
      if (out_valid !== 1'b0) $display("FAIL single_early %0d: got out_valid %b expected 0", i, out_valid);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if (out_valid !== 1'b1 || result !== te[i]) $display("FAIL single_result %0d: got %b/%0d expected 1/%0d", i, out_valid, result, te[i]);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if (out_valid !== 1'b0 || result !== te[i]) $display("FAIL single_hold %0d: got %b/%0d expected 0/%0d", i, out_valid, result, te[i]);
      else pass_count++;
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    for (int c = 0; c < 67; c++) begin
      check_count++;
      if (c >= 2 && c < 66) begin
        exp = ((c - 2) / 8) * ((c - 2) % 8);
        if (out_valid !== 1'b1 || result !== exp[5:0]) $display("FAIL b2b_result %0d: got %b/%0d expected 1/%0d", c - 2, out_valid, result, exp);
        else pass_count++;
      end else begin
        if (out_valid !== 1'b0) $display("FAIL b2b_idle %0d: got out_valid %b expected 0", c, out_valid);
        else pass_count++;
      end
      if (c < 64) begin
        a = c[5:3]; b = c[2:0]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_init();
    int ov = 0;
    int rise = 0;
    rst_n = 1'b0; in_valid = 1'b1; a = 3'd5; b = 3'd5;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (out_valid) ov++;
      if (rise == 0 && init_done) rise = k;
    end
    in_valid = 1'b0;
    check_count++;
    if (ov !== 0) $display("FAIL ignore_out_valid: got %0d valid cycles expected 0", ov);
    else pass_count++;
    check_count++;
    if (rise !== 64) $display("FAIL ignore_init_rise: got cycle %0d expected 64", rise);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (out_valid !== 1'b1 || result !== 6'd25) $display("FAIL ignore_first_result: got %b/%0d expected 1/25", out_valid, result);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (out_valid !== 1'b0) $display("FAIL ignore_single: got out_valid %b expected 0", out_valid);
    else pass_count++;
  endtask

  task automatic test_reset_inflight();
    int ov = 0;
    int rise = 0;
    a = 3'd2; b = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    a = 3'd4; b = 3'd5; in_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    check_count++;
    if (out_valid !== 1'b0 || init_done !== 1'b0 || result !== 6'd0) $display("FAIL inflight_reset: got %b/%b/%0d expected 0/0/0", out_valid, init_done, result);
    else pass_count++;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (out_valid) ov++;
      if (rise == 0 && init_done) rise = k;
    end
    check_count++;
    if (ov !== 0) $display("FAIL inflight_out_valid: got %0d valid cycles expected 0", ov);
    else pass_count++;
    check_count++;
    if (rise !== 64) $display("FAIL inflight_init_rise: got cycle %0d expected 64", rise);
    else pass_count++;
    a = 3'd6; b = 3'd7; in_valid = 1'b1;
    @(negedge clk);
    a = 3'd2; b = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_count++;
    if (out_valid !== 1'b1 || result !== 6'd42) $display("FAIL inflight_after_1: got %b/%0d expected 1/42", out_valid, result);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (out_valid !== 1'b1 || result !== 6'd6) $display("FAIL inflight_after_2: got %b/%0d expected 1/6", out_valid, result);
    else pass_count++;
    @(negedge clk);
  endtask

  task automatic test_wide();
    logic [3:0] ta [3] = '{4'd15, 4'd0, 4'd9};
    logic [1:0] tb [3] = '{2'd3, 2'd3, 2'd2};
    logic [5:0] te [3] = '{6'd45, 6'd0, 6'd18};
    check_count++;
    if (init_done2 !== 1'b1) $display("FAIL wide_ready: got init_done %b expected 1", init_done2);
    else pass_count++;
    for (int i = 0; i < 3; i++) begin
      a2 = ta[i]; b2 = tb[i]; in_valid2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      check_count++;
      if (out_valid2 !== 1'b0) $display("FAIL wide_early %0d: got out_valid %b expected 0", i, out_valid2);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if (out_valid2 !== 1'b1 || result2 !== te[i]) $display("FAIL wide_result %0d: got %b/%0d expected 1/%0d", i, out_valid2, result2, te[i]);
      else pass_count++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single();
    test_back_to_back();
    test_ignore_init();
    test_reset_inflight();
    test_wide();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
